// File: rtl/mux_pkg.sv
// Shared sizing helpers for the pipelined binary-select mux tree.
package mux_pkg;

  function automatic int stages(input int width_log, input int stage_lvl);
    return (stage_lvl < 1) ? 1 : (width_log + stage_lvl - 1) / stage_lvl;
  endfunction

  function automatic int pad(input int width);
    return 1 << $clog2(width);
  endfunction

  // Tree levels handled by stage s; the last stage may take fewer than stage_lvl.
  function automatic int stage_lvl_at(input int width_log, input int stage_lvl, input int s);
    int rem;
    rem = width_log - s * stage_lvl;
    return (rem < stage_lvl) ? rem : stage_lvl;
  endfunction

endpackage

// File: rtl/mux_bin_stage.sv
// One pipeline stage: reduces the array by 2**LVL using the low select bits,
// then registers the reduced array, the remaining select bits and valid.
module mux_bin_stage
  import mux_pkg::*;
#(
  parameter type DAT_T    = logic [8-1:0],
  parameter int  IN_WIDTH = 2,
  parameter int  LVL      = 1,
  parameter int  SEL_W    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_vld,
  output logic             i_rdy,
  input  logic [SEL_W-1:0] i_sel,
  input  DAT_T             i_ary [IN_WIDTH-1:0],
  output logic             o_vld,
  input  logic             o_rdy,
  output logic [SEL_W-1:0] o_sel,
  output DAT_T             o_ary [(IN_WIDTH >> LVL)-1:0]
);

  localparam int OUT_W = IN_WIDTH >> LVL;
  localparam int IW    = $clog2(IN_WIDTH);

  logic             r_vld;
  logic [SEL_W-1:0] r_sel;
  DAT_T             r_ary [OUT_W-1:0];
  DAT_T             w_red [OUT_W-1:0];
  logic [IW-1:0]    w_idx;
  logic             w_rdy;

  // Group j of 2**LVL adjacent entries collapses to the one picked by the low select bits.
  always_comb begin
    w_idx = '0;
    for (int j = 0; j < OUT_W; j++) begin
      w_idx    = IW'(j << LVL) | IW'(i_sel[LVL-1:0]);
      w_red[j] = i_ary[w_idx];
    end
  end

  // An empty stage always loads, so bubbles collapse while downstream stalls.
  assign w_rdy = ~r_vld | o_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= 1'b0;
      r_sel <= '0;
      for (int j = 0; j < OUT_W; j++) r_ary[j] <= '0;
    end else if (w_rdy) begin
      r_vld <= i_vld;
      r_sel <= i_sel >> LVL;
      r_ary <= w_red;
    end
  end

  assign i_rdy = w_rdy;
  assign o_vld = r_vld;
  assign o_sel = r_sel;
  assign o_ary = r_ary;

endmodule

// File: rtl/mux_bin_pipe.sv
// Pipelined radix-2 mux tree with binary select and valid/ready on both sides;
// a register stage follows every STAGE_LVL tree levels.
module mux_bin_pipe
  import mux_pkg::*;
#(
  parameter type DAT_T          = logic [8-1:0],
  parameter int  WIDTH          = 32,
  parameter int  STAGE_LVL      = 1,
  parameter int  IMPLEMENTATION = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_vld,
  output logic                     i_rdy,
  input  logic [$clog2(WIDTH)-1:0] i_bin,
  input  DAT_T                     i_ary [WIDTH-1:0],
  output logic                     o_vld,
  input  logic                     o_rdy,
  output DAT_T                     o_dat
);

  localparam int WIDTH_LOG = $clog2(WIDTH);
  localparam int STAGES    = stages(WIDTH_LOG, STAGE_LVL);
  localparam int PAD       = pad(WIDTH);

  if (WIDTH < 2) begin : g_chk_width
    $fatal(1, "mux_bin_pipe: WIDTH must be >= 2");
  end
  if (STAGE_LVL < 1 || STAGE_LVL > WIDTH_LOG) begin : g_chk_lvl
    $fatal(1, "mux_bin_pipe: STAGE_LVL must be in 1..WIDTH_LOG");
  end
  if (IMPLEMENTATION != 0) begin : g_chk_impl
    $fatal(1, "mux_bin_pipe: unsupported IMPLEMENTATION");
  end

  DAT_T                 w_pad [PAD-1:0];
  logic                 w_vld [STAGES:0];
  logic                 w_rdy [STAGES:0];
  logic [WIDTH_LOG-1:0] w_sel [STAGES:0];
  logic [WIDTH_LOG-1:0] w_sel_unused;

  // Out-of-range selects land on zero entries, so they simply return zero.
  for (genvar k = 0; k < PAD; k++) begin : g_pad
    if (k < WIDTH) begin : g_dat
      assign w_pad[k] = i_ary[k];
    end else begin : g_zero
      assign w_pad[k] = '0;
    end
  end

  assign w_vld[0]      = i_vld;
  assign w_sel[0]      = i_bin;
  assign w_rdy[STAGES] = o_rdy;

  for (genvar s = 0; s < STAGES; s++) begin : g_stg
    localparam int IN_W  = PAD >> (s * STAGE_LVL);
    localparam int LVL   = stage_lvl_at(WIDTH_LOG, STAGE_LVL, s);
    localparam int OUT_W = IN_W >> LVL;

    DAT_T w_ary_in  [IN_W-1:0];
    DAT_T w_ary_out [OUT_W-1:0];

    if (s == 0) begin : g_head
      assign w_ary_in = w_pad;
    end else begin : g_body
      assign w_ary_in = g_stg[s-1].w_ary_out;
    end

    mux_bin_stage #(
      .DAT_T   (DAT_T),
      .IN_WIDTH(IN_W),
      .LVL     (LVL),
      .SEL_W   (WIDTH_LOG)
    ) u_stage (
      .clk  (clk),
      .rst  (rst),
      .i_vld(w_vld[s]),
      .i_rdy(w_rdy[s]),
      .i_sel(w_sel[s]),
      .i_ary(w_ary_in),
      .o_vld(w_vld[s+1]),
      .o_rdy(w_rdy[s+1]),
      .o_sel(w_sel[s+1]),
      .o_ary(w_ary_out)
    );
  end

  // All select bits are consumed by the last stage.
  assign w_sel_unused = w_sel[STAGES];

  assign i_rdy = w_rdy[0];
  assign o_vld = w_vld[STAGES];
  assign o_dat = g_stg[STAGES-1].w_ary_out[0];

endmodule
